// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy encoding,
// the NOP control bundle and the widths used at each stage boundary.
package pipe_pkg;
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1,
      SKIDDED = 2'd2
   } occ_e;

   // Wide enough for any stage's control bundle; instances take the low CTRL_W bits.
   localparam int MAX_CTRL_W = 64;
   localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = '0;

   localparam int IDEX_CTRL_W  = 10;
   localparam int IDEX_DATA_W  = 112;
   localparam int EXMEM_CTRL_W = 5;
   localparam int EXMEM_DATA_W = 71;
   localparam int MEMWB_CTRL_W = 2;
   localparam int MEMWB_DATA_W = 69;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter clocked on the falling edge; cleared only by reset.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic stage-boundary register: valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating stall counter. State moves on the falling edge.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 10,
   parameter int DATA_W = 112,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   occ_e              state_q, state_d;
   logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
   logic              accept, consume;

   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   // With a skid entry, ready depends only on registered state, so there is
   // no combinational path from out_ready back upstream.
   generate
      if (SKID) begin : g_skid_rdy
         assign in_ready = (state_q != SKIDDED);
      end else begin : g_comb_rdy
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      head_ctrl_d = head_ctrl_q;
      head_data_d = head_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d     = EMPTY;
         head_ctrl_d = '0;
         head_data_d = '0;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d     = FULL;
                  head_ctrl_d = in_ctrl;
                  head_data_d = in_data;
               end
            end
            FULL: begin
               if (accept && consume) begin
                  head_ctrl_d = in_ctrl;
                  head_data_d = in_data;
               end else if (accept && SKID) begin
                  state_d     = SKIDDED;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            SKIDDED: begin
               if (consume) begin
                  state_d     = FULL;
                  head_ctrl_d = skid_ctrl_q;
                  head_data_d = skid_data_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         head_ctrl_q <= '0;
         head_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         head_ctrl_q <= head_ctrl_d;
         head_data_q <= head_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign out_ctrl  = out_valid ? head_ctrl_q : NOP_CTRL[CTRL_W-1:0];
   assign out_data  = head_data_q;
   assign occupancy = state_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid, no-skid and narrow-counter instances share one stimulus.
module tb_pipe_stage_reg;
   localparam int CW = 10;
   localparam int DW = 112;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
   logic [DW-1:0] a_out_data, b_out_data, c_out_data;
   logic [1:0]    a_occ, b_occ, c_occ;
   logic [15:0]   a_cnt, b_cnt;
   logic [3:0]    c_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_cnt));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(16)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_cnt));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(4)) u_c (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ), .stall_cnt(c_cnt));

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      n_chk++;
      if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
         n_fail++; $display("FAIL reset_in_ready got %b exp 111", {a_in_ready, b_in_ready, c_in_ready});
      end
      n_chk++;
      if ({a_out_valid, a_out_ctrl, a_out_data, a_occ, a_cnt} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got v=%b c=%h d=%h o=%0d s=%0d exp all zero",
                            a_out_valid, a_out_ctrl, a_out_data, a_occ, a_cnt);
      end
      #6 reset = 1'b1;
   endtask

   task automatic test_stream;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, CW'(10'h155), DW'(i), 1'b1, 1'b0);
         step();
         n_chk++;
         if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, CW'(10'h155), DW'(i)}) begin
            n_fail++; $display("FAIL stream_a_%0d got v=%b c=%h d=%h exp v=1 c=155 d=%h",
                               i, a_out_valid, a_out_ctrl, a_out_data, i);
         end
         n_chk++;
         if ({b_out_valid, b_out_data, c_out_valid, c_out_data} !== {1'b1, DW'(i), 1'b1, DW'(i)}) begin
            n_fail++; $display("FAIL stream_bc_%0d got b=%h c=%h exp %h", i, b_out_data, c_out_data, i);
         end
         n_chk++;
         if ({a_occ, b_occ, a_cnt, b_cnt} !== {2'd1, 2'd1, 16'd0, 16'd0}) begin
            n_fail++; $display("FAIL stream_occ_cnt_%0d got occ=%0d/%0d cnt=%0d/%0d exp 1/1 0/0",
                               i, a_occ, b_occ, a_cnt, b_cnt);
         end
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      n_chk++;
      if ({a_out_valid, a_out_ctrl, a_occ, b_out_valid, b_out_ctrl} !== '0) begin
         n_fail++; $display("FAIL stream_drain got a_v=%b a_c=%h a_o=%0d b_v=%b b_c=%h exp zeros",
                            a_out_valid, a_out_ctrl, a_occ, b_out_valid, b_out_ctrl);
      end
   endtask

   task automatic test_stall;
      drive(1'b1, CW'(10'h00A), DW'(112'hA), 1'b0, 1'b0);
      step();
      drive(1'b1, CW'(10'h00B), DW'(112'hB), 1'b0, 1'b0);
      #1;
      n_chk++;
      if ({a_in_ready, b_in_ready} !== 2'b10) begin
         n_fail++; $display("FAIL stall_ready_full got a=%b b=%b exp a=1 b=0", a_in_ready, b_in_ready);
      end
      step();
      n_chk++;
      if ({a_occ, a_in_ready, a_out_data, a_cnt} !== {2'd2, 1'b0, DW'(112'hA), 16'd1}) begin
         n_fail++; $display("FAIL stall_skidded got occ=%0d rdy=%b d=%h cnt=%0d exp 2 0 a 1",
                            a_occ, a_in_ready, a_out_data, a_cnt);
      end
      n_chk++;
      if ({b_occ, b_in_ready, b_out_data, b_cnt} !== {2'd1, 1'b0, DW'(112'hA), 16'd1}) begin
         n_fail++; $display("FAIL stall_noskid got occ=%0d rdy=%b d=%h cnt=%0d exp 1 0 a 1",
                            b_occ, b_in_ready, b_out_data, b_cnt);
      end
      step();
      n_chk++;
      if ({a_occ, b_occ, a_out_ctrl, a_cnt, b_cnt} !== {2'd2, 2'd1, CW'(10'h00A), 16'd2, 16'd2}) begin
         n_fail++; $display("FAIL stall_hold got occ=%0d/%0d c=%h cnt=%0d/%0d exp 2/1 00a 2/2",
                            a_occ, b_occ, a_out_ctrl, a_cnt, b_cnt);
      end
      out_ready = 1'b1;
      #1;
      n_chk++;
      if ({a_in_ready, b_in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL stall_release_ready got a=%b b=%b exp a=0 b=1", a_in_ready, b_in_ready);
      end
      step();
      in_valid = 1'b0;
      n_chk++;
      if ({a_out_valid, a_out_ctrl, a_out_data, a_occ, b_out_data, b_occ} !==
          {1'b1, CW'(10'h00B), DW'(112'hB), 2'd1, DW'(112'hB), 2'd1}) begin
         n_fail++; $display("FAIL stall_second got a_d=%h a_c=%h a_o=%0d b_d=%h b_o=%0d exp b 00b 1 b 1",
                            a_out_data, a_out_ctrl, a_occ, b_out_data, b_occ);
      end
      step();
      n_chk++;
      if ({a_out_valid, b_out_valid, a_cnt, b_cnt} !== {1'b0, 1'b0, 16'd2, 16'd2}) begin
         n_fail++; $display("FAIL stall_empty got v=%b/%b cnt=%0d/%0d exp 0/0 2/2",
                            a_out_valid, b_out_valid, a_cnt, b_cnt);
      end
   endtask

   task automatic test_flush;
      drive(1'b1, CW'(10'h00C), DW'(112'hC), 1'b0, 1'b0);
      step();
      drive(1'b1, CW'(10'h00D), DW'(112'hD), 1'b0, 1'b0);
      step();
      n_chk++;
      if ({a_occ, c_occ} !== {2'd2, 2'd2}) begin
         n_fail++; $display("FAIL flush_setup got occ=%0d/%0d exp 2/2", a_occ, c_occ);
      end
      drive(1'b1, CW'(10'h00E), DW'(112'hE), 1'b0, 1'b1);
      step();
      n_chk++;
      if ({a_out_valid, a_out_ctrl, a_occ, b_out_valid, b_out_ctrl, b_occ, c_occ} !== '0) begin
         n_fail++; $display("FAIL flush_bubble got a v=%b c=%h o=%0d b v=%b c=%h o=%0d c_o=%0d exp zeros",
                            a_out_valid, a_out_ctrl, a_occ, b_out_valid, b_out_ctrl, b_occ, c_occ);
      end
      n_chk++;
      if ({a_cnt, b_cnt} !== {16'd4, 16'd4}) begin
         n_fail++; $display("FAIL flush_cnt got %0d/%0d exp 4/4", a_cnt, b_cnt);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      n_chk++;
      if ({a_out_valid, a_occ, a_out_data, b_out_data} !== '0) begin
         n_fail++; $display("FAIL flush_nocapture got v=%b o=%0d d=%h/%h exp zeros",
                            a_out_valid, a_occ, a_out_data, b_out_data);
      end
      drive(1'b1, CW'(10'h005), DW'(112'h5), 1'b1, 1'b0);
      step();
      n_chk++;
      if ({a_out_valid, a_out_data, c_out_ctrl} !== {1'b1, DW'(112'h5), CW'(10'h005)}) begin
         n_fail++; $display("FAIL flush_next got v=%b d=%h c=%h exp 1 5 005", a_out_valid, a_out_data, c_out_ctrl);
      end
   endtask

   task automatic test_saturate;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 11) begin
            n_chk++;
            if (c_cnt !== 4'd15) begin
               n_fail++; $display("FAIL sat_reach got %0d exp 15", c_cnt);
            end
         end
      end
      n_chk++;
      if ({c_cnt, a_cnt} !== {4'd15, 16'd24}) begin
         n_fail++; $display("FAIL sat_hold got c=%0d a=%0d exp 15 24", c_cnt, a_cnt);
      end
      n_chk++;
      if ({a_out_valid, a_out_data, a_occ} !== {1'b1, DW'(112'h5), 2'd1}) begin
         n_fail++; $display("FAIL sat_stable got v=%b d=%h o=%0d exp 1 5 1", a_out_valid, a_out_data, a_occ);
      end
   endtask

   task automatic test_async_reset;
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if ({a_out_valid, a_out_ctrl, a_out_data, a_occ, a_cnt, c_cnt} !== '0) begin
         n_fail++; $display("FAIL async_reset got v=%b c=%h d=%h o=%0d s=%0d/%0d exp zeros",
                            a_out_valid, a_out_ctrl, a_out_data, a_occ, a_cnt, c_cnt);
      end
      n_chk++;
      if ({a_in_ready, b_in_ready, b_out_valid} !== 3'b110) begin
         n_fail++; $display("FAIL async_reset_ready got %b exp 110", {a_in_ready, b_in_ready, b_out_valid});
      end
      #2 reset = 1'b1;
      drive(1'b1, CW'(10'h003), DW'(112'h3), 1'b1, 1'b0);
      step();
      n_chk++;
      if ({a_out_valid, a_out_data, a_occ, b_out_data} !== {1'b1, DW'(112'h3), 2'd1, DW'(112'h3)}) begin
         n_fail++; $display("FAIL post_reset_accept got v=%b d=%h o=%0d b=%h exp 1 3 1 3",
                            a_out_valid, a_out_data, a_occ, b_out_data);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_saturate();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register that succeeds the fixed-width stage registers between decode, execute, memory and writeback. It carries a generic control bundle plus data payload with a valid/ready handshake, optional two-entry skid buffering, flush-to-bubble and a saturating stall counter. One instance sits on each stage boundary (ID/EX, EX/MEM, MEM/WB), so hazard logic drives stall and flush through one uniform interface.

## Interface
- `CTRL_W`, default 10: control bundle width (EX/M/WB fields packed by the stage).
- `DATA_W`, default 112: payload width (operands, PC+4, imm16, register numbers).
- `SKID`, default 1: 1 gives a two-entry skid buffer with a registered `in_ready`; 0 gives a single entry with a combinational `in_ready`.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk` input 1: stage clock. All state updates on the falling edge, matching the pipeline.
- `reset` input 1: asynchronous, active-low reset.
- `flush` input 1: discard all held entries and turn them into bubbles.
- `in_valid` input 1: upstream stage presents an instruction.
- `in_ready` output 1: this register accepts on the current edge.
- `in_ctrl` input CTRL_W: control bundle.
- `in_data` input DATA_W: payload.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: downstream stage consumes the head.
- `out_ctrl` output CTRL_W: head control. Forced all-zero (NOP) whenever `out_valid`=0.
- `out_data` output DATA_W: head payload.
- `occupancy` output 2: number of held entries (0..2).
- `stall_cnt` output CNT_W: saturating count of stalled cycles.

## Operation
- Accept occurs when `in_valid && in_ready`. Consume occurs when `out_valid && out_ready`.
- States: EMPTY (occupancy 0), FULL (1), SKIDDED (2; only reachable when SKID=1).
- From EMPTY:
  - Accept → FULL; the head loads the input.
- From FULL:
  - Accept with consume → FULL; the head loads the input.
  - Accept without consume → SKIDDED; the skid entry loads the input.
  - Consume only → EMPTY.
- From SKIDDED:
  - Consume → FULL; the head loads the skid entry.
  - No accept is possible in this state.
- `in_ready`:
  - SKID=1: `in_ready = (occupancy != 2)`, registered.
  - SKID=0: `in_ready = !out_valid || out_ready`. Occupancy never exceeds 1.
- `flush` has priority over everything:
  - Occupancy goes to 0.
  - Head and skid ctrl and data are zeroed.
  - A simultaneous accept is dropped.
  - The stall counter is unaffected.
- `stall_cnt` increments on each edge where `out_valid && !out_ready`. It saturates at 2^CNT_W−1 and never wraps. It clears only on reset.
- Data ordering is strictly FIFO. The skid entry is never visible on the outputs.

## Timing
- Latency: an input accepted on falling edge N appears on `out_*` after edge N, i.e. one stage.
- Throughput: 1 per cycle with `out_ready`=1 continuously. In SKID=1, full rate is sustained across single-cycle downstream stalls without a combinational ready path.
- Reset (asynchronous assert, all outputs):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0.
  - `in_ready`=1 in both modes.
- Reset deassertion mid-operation: the state is already EMPTY. The first accept is allowed on the first falling edge after release.
- Flush and reset are both honoured on a falling edge even when `out_ready`=0.
- `out_ctrl`/`out_data` are stable while `out_valid && !out_ready`.

## Structure
- Shared package `pipe_pkg`:
  - occupancy state encoding (EMPTY=2'd0, FULL=2'd1, SKIDDED=2'd2);
  - `NOP_CTRL` constant (all-zero);
  - default widths for the ID/EX, EX/MEM and MEM/WB instances.
- One natural sub-module: `sat_counter` (parameter CNT_W; inputs clk, reset, inc; output count), used for `stall_cnt`.
- Head and skid entries are inline registers. No further hierarchy.

## Test plan
- Reset then stream ctrl=0x155, data=0x1..0x8 with `out_ready`=1 → each value appears one falling edge later; `occupancy` stays 1; `stall_cnt`=0.
- SKID=1, hold `out_ready`=0 while presenting 0xA then 0xB → `occupancy`=2, `in_ready`=0, head=0xA. Release → 0xA then 0xB in order. `stall_cnt` equals the stalled edge count.
- SKID=0, same stimulus → 0xB is held upstream (`in_ready`=0 combinationally); `occupancy` never exceeds 1.
- Flush asserted in SKIDDED with a simultaneous `in_valid` → next edge `out_valid`=0, `out_ctrl`=0, `occupancy`=0, and the input is not captured.
- CNT_W=4 with `out_ready`=0 for 20 edges → `stall_cnt` saturates at 15.
- Assert `reset` asynchronously between edges while FULL → outputs clear immediately. After release, accept 0x3 → it appears after one edge.
